// File: rtl/txshift.sv
// USRT transmit serializer: latches one byte into an 11-bit frame (start, 8 data LSB first, parity, stop)
// and shifts it out one bit per baud-clock rising edge; pops the TX register only when idle and enabled.
module txshift (
    input  logic       i_Pclk,
    input  logic       i_Reset,
    input  logic       i_Bclk,
    input  logic       i_Enable,
    input  logic [1:0] i_Parity,
    input  logic       i_Valid,
    input  logic [7:0] i_Data,
    output logic       o_Pop,
    output logic       o_Tx_Serial,
    output logic       o_Busy,
    output logic       o_Done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT} state_t;

    state_t      state_q, state_d;
    logic        bclk_q;
    logic [10:0] frame_q, frame_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        edge_w;
    logic        load_w;
    logic        par_w;

    assign edge_w = i_Bclk & ~bclk_q;
    assign load_w = (state_q == S_IDLE) & i_Enable & i_Valid;

    // Mode 11 behaves as "none": the parity slot becomes a second stop bit.
    always_comb begin
        case (i_Parity)
            2'b01:   par_w = ^i_Data;
            2'b10:   par_w = ~^i_Data;
            default: par_w = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (load_w) begin
                    frame_d = {1'b1, par_w, i_Data, 1'b0};
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (edge_w) begin
                    tx_d    = frame_q[0];
                    frame_d = {1'b1, frame_q[10:1]};
                    cnt_d   = 4'd1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (edge_w) begin
                    if (cnt_q == 4'd11) begin
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        tx_d    = frame_q[0];
                        frame_d = {1'b1, frame_q[10:1]};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            bclk_q  <= 1'b0;
            frame_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bclk_q  <= i_Bclk;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign o_Pop       = load_w & ~i_Reset;
    assign o_Tx_Serial = tx_q;
    assign o_Busy      = (state_q != S_IDLE);
    assign o_Done      = done_q;

endmodule

// File: tb/tb_txshift.sv
// Bench for txshift: drives a baud clock, predicts the line from edge counts since load.
module tb_txshift;

    logic       i_Pclk, i_Reset, i_Bclk, i_Enable, i_Valid;
    logic [1:0] i_Parity;
    logic [7:0] i_Data;
    logic       o_Pop, o_Tx_Serial, o_Busy, o_Done;

    int vectors = 0;
    int errors  = 0;
    int baud    = 5;
    int bcnt    = 0;
    int pops    = 0;
    int dones   = 0;

    txshift dut (
        .i_Pclk(i_Pclk), .i_Reset(i_Reset), .i_Bclk(i_Bclk), .i_Enable(i_Enable),
        .i_Parity(i_Parity), .i_Valid(i_Valid), .i_Data(i_Data),
        .o_Pop(o_Pop), .o_Tx_Serial(o_Tx_Serial), .o_Busy(o_Busy), .o_Done(o_Done)
    );

    initial begin
        i_Pclk = 1'b0;
        forever #5 i_Pclk = ~i_Pclk;
    end

    initial begin
        i_Bclk = 1'b0;
        forever begin
            @(posedge i_Pclk);
            #1;
            bcnt++;
            if (bcnt >= baud) begin
                bcnt   = 0;
                i_Bclk = ~i_Bclk;
            end
        end
    end

    always @(negedge i_Pclk) begin
        if (o_Pop === 1'b1)  pops++;
        if (o_Done === 1'b1) dones++;
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic [1:0] p);
        logic pb;
        case (p)
            2'b01:   pb = ^d;
            2'b10:   pb = ~^d;
            default: pb = 1'b1;
        endcase
        return {1'b1, pb, d, 1'b0};
    endfunction

    // Sends one frame. Expected line = frame[n-1] where n counts Bclk rises since load.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] p, input bit chained,
                             input bit keep_valid, input logic [7:0] next_d,
                             input int abort_n, input int dropen_n, input string name);
        logic [10:0] f;
        logic        exp_line;
        bit          prev, cur;
        int          n;
        f = exp_frame(d, p);
        if (!chained) begin
            @(posedge i_Pclk); #1;
            i_Enable = 1'b1; i_Valid = 1'b1; i_Data = d; i_Parity = p;
            @(negedge i_Pclk);
        end
        vectors++;
        if (o_Pop !== 1'b1 || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s load: pop=%b busy=%b, required pop=1 busy=0", name, o_Pop, o_Busy);
        end
        @(posedge i_Pclk);
        prev = i_Bclk;
        n    = 0;
        #1;
        i_Valid = keep_valid;
        i_Data  = keep_valid ? next_d : 8'($urandom);
        if (!keep_valid) i_Parity = 2'($urandom);
        for (int c = 0; c < 30 * baud + 20; c++) begin
            @(posedge i_Pclk);
            cur = i_Bclk;
            if (cur && !prev) n++;
            prev = cur;
            #1;
            if (n == dropen_n) i_Enable = 1'b0;
            if (n == abort_n) begin
                i_Reset = 1'b1;
                @(posedge i_Pclk); #1;
                i_Reset = 1'b0;
                for (int k = 0; k < 4 * baud; k++) begin
                    @(negedge i_Pclk);
                    vectors++;
                    if (o_Tx_Serial !== 1'b1 || o_Busy !== 1'b0 || o_Done !== 1'b0) begin
                        errors++;
                        $display("FAIL %s abort cyc%0d: line=%b busy=%b done=%b, required 1 0 0",
                                 name, k, o_Tx_Serial, o_Busy, o_Done);
                    end
                end
                return;
            end
            @(negedge i_Pclk);
            vectors++;
            if (n >= 12) begin
                if (o_Done !== 1'b1 || o_Busy !== 1'b0 || o_Tx_Serial !== 1'b1 ||
                    o_Pop !== (keep_valid && i_Enable)) begin
                    errors++;
                    $display("FAIL %s done: done=%b busy=%b line=%b pop=%b, required 1 0 1 %b",
                             name, o_Done, o_Busy, o_Tx_Serial, o_Pop, keep_valid && i_Enable);
                end
                return;
            end
            exp_line = (n == 0) ? 1'b1 : f[n-1];
            if (o_Tx_Serial !== exp_line || o_Busy !== 1'b1 || o_Done !== 1'b0 || o_Pop !== 1'b0) begin
                errors++;
                $display("FAIL %s bit%0d: line=%b busy=%b done=%b pop=%b, required %b 1 0 0",
                         name, n, o_Tx_Serial, o_Busy, o_Done, o_Pop, exp_line);
            end
        end
        errors++;
        $display("FAIL %s timeout: no o_Done within %0d cycles, required one", name, 30 * baud + 20);
    endtask

    task automatic test_reset;
        i_Reset = 1'b1; i_Enable = 1'b1; i_Valid = 1'b1; i_Data = 8'h35; i_Parity = 2'b01;
        repeat (3) @(posedge i_Pclk);
        @(negedge i_Pclk);
        vectors++;
        if (o_Tx_Serial !== 1'b1 || o_Busy !== 1'b0 || o_Pop !== 1'b0 || o_Done !== 1'b0) begin
            errors++;
            $display("FAIL reset: line=%b busy=%b pop=%b done=%b, required 1 0 0 0",
                     o_Tx_Serial, o_Busy, o_Pop, o_Done);
        end
        i_Valid = 1'b0;
        @(posedge i_Pclk); #1;
        i_Reset = 1'b0;
        repeat (4) begin
            @(negedge i_Pclk);
            vectors++;
            if (o_Tx_Serial !== 1'b1 || o_Busy !== 1'b0 || o_Pop !== 1'b0) begin
                errors++;
                $display("FAIL idle_novalid: line=%b busy=%b pop=%b, required 1 0 0",
                         o_Tx_Serial, o_Busy, o_Pop);
            end
        end
    endtask

    task automatic test_parity_modes;
        baud = 5;
        run_frame(8'h35, 2'b01, 0, 0, 8'h00, -1, -1, "even_35");
        run_frame(8'h5D, 2'b10, 0, 0, 8'h00, -1, -1, "odd_5D");
        run_frame(8'h35, 2'b00, 0, 0, 8'h00, -1, -1, "none_35");
        run_frame(8'h35, 2'b11, 0, 0, 8'h00, -1, -1, "p11_35");
    endtask

    task automatic test_back_to_back;
        int p0, d0;
        baud = 5;
        repeat (3) @(posedge i_Pclk);
        p0 = pops; d0 = dones;
        run_frame(8'h35, 2'b01, 0, 1, 8'hA5, -1, -1, "b2b_first");
        run_frame(8'hA5, 2'b01, 1, 0, 8'h00, -1, -1, "b2b_second");
        repeat (3) @(negedge i_Pclk);
        vectors++;
        if (pops - p0 != 2 || dones - d0 != 2) begin
            errors++;
            $display("FAIL b2b_counts: pops=%0d dones=%0d, required 2 2", pops - p0, dones - d0);
        end
    endtask

    task automatic test_reset_midframe;
        int d0;
        baud = 5;
        d0 = dones;
        run_frame(8'hC3, 2'b01, 0, 0, 8'h00, 5, -1, "abort");
        vectors++;
        if (dones != d0) begin
            errors++;
            $display("FAIL abort_done: o_Done pulses=%0d, required 0", dones - d0);
        end
        run_frame(8'h35, 2'b01, 0, 0, 8'h00, -1, -1, "after_abort");
    endtask

    task automatic test_enable;
        baud = 5;
        @(posedge i_Pclk); #1;
        i_Enable = 1'b0; i_Valid = 1'b1; i_Data = 8'h96; i_Parity = 2'b10;
        for (int k = 0; k < 10 * baud; k++) begin
            @(negedge i_Pclk);
            vectors++;
            if (o_Pop !== 1'b0 || o_Tx_Serial !== 1'b1 || o_Busy !== 1'b0) begin
                errors++;
                $display("FAIL disabled cyc%0d: pop=%b line=%b busy=%b, required 0 1 0",
                         k, o_Pop, o_Tx_Serial, o_Busy);
            end
        end
        @(posedge i_Pclk); #1;
        i_Enable = 1'b1;
        @(negedge i_Pclk);
        run_frame(8'h96, 2'b10, 1, 1, 8'h96, -1, 3, "en_drop");
        for (int k = 0; k < 10 * baud; k++) begin
            @(negedge i_Pclk);
            vectors++;
            if (o_Pop !== 1'b0 || o_Tx_Serial !== 1'b1 || o_Busy !== 1'b0) begin
                errors++;
                $display("FAIL en_drop_after cyc%0d: pop=%b line=%b busy=%b, required 0 1 0",
                         k, o_Pop, o_Tx_Serial, o_Busy);
            end
        end
        @(posedge i_Pclk); #1;
        i_Valid = 1'b0;
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++) begin
            baud = int'($urandom_range(2, 7));
            repeat (int'($urandom_range(0, 5))) @(posedge i_Pclk);
            run_frame(8'($urandom), 2'($urandom), 0, 0, 8'h00, -1, -1, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        i_Reset = 1'b1; i_Enable = 1'b0; i_Valid = 1'b0; i_Data = 8'h00; i_Parity = 2'b00;
        test_reset;
        test_parity_modes;
        test_back_to_back;
        test_reset_midframe;
        test_enable;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
